s2mm_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing one S2MM write channel among NUM_REQ requesters; the channel comprises request, write-data stream and write response.
- Typical requesters: traffic generators, test data generators and DMA clients.
- A grant covers one complete transaction: request, then data burst through wdata_last, then write response.
- Only one transaction is outstanding at a time. The block sits between the requesters and the datamover S2MM command/data interface.

---
 rtl/s2mm_wr_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_s2mm_wr_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_wr_arbiter.sv
// s2mm_wr_arbiter
//   Round-robin arbiter that shares one S2MM write channel (request, write-data
//   stream, write response) among NUM_REQ requesters. A grant covers one whole
//   transaction: request, data burst through wdata_last, then write response.
//   Only one transaction is outstanding at a time.
//
// Optional feature macro: WR_ARB_TIMEOUT_EN
//   Defined   : response watchdog; after TIMEOUT_CYC cycles in RESP without a
//               downstream response, an SLVERR (2'b10) is returned to the owner
//               and timeout_flag is set (sticky).
//   Undefined : no watchdog, RESP waits indefinitely, timeout_flag tied 0.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   s_wreq_*                   per-requester request channel (packed fields)
//   s_wdata_*                  per-requester write-data stream (packed data)
//   s_wresp_valid / s_wresp    response strobe to the owner / broadcast code
//   m_wreq_*                   downstream request to the datamover
//   m_wdata_*                  downstream write-data stream
//   m_wresp_valid / m_wresp    downstream write response
//   grant_id                   current or last owner
//   busy                       high whenever not IDLE
//   stray_resp                 sticky: downstream response seen outside RESP
//   timeout_flag               sticky watchdog flag
module s2mm_wr_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int SIZE_W      = 16,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic [NUM_REQ-1:0]                              s_wreq_valid,
    output logic [NUM_REQ-1:0]                              s_wreq_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]                       s_wreq_addr,
    input  logic [NUM_REQ*SIZE_W-1:0]                       s_wreq_size,
    input  logic [NUM_REQ-1:0]                              s_wdata_valid,
    output logic [NUM_REQ-1:0]                              s_wdata_ready,
    input  logic [NUM_REQ-1:0]                              s_wdata_last,
    input  logic [NUM_REQ*DATA_W-1:0]                       s_wdata,
    output logic [NUM_REQ-1:0]                              s_wresp_valid,
    output logic [1:0]                                      s_wresp,
    output logic                                            m_wreq_valid,
    input  logic                                            m_wreq_ready,
    output logic [ADDR_W-1:0]                               m_wreq_addr,
    output logic [SIZE_W-1:0]                               m_wreq_size,
    output logic                                            m_wdata_valid,
    input  logic                                            m_wdata_ready,
    output logic                                            m_wdata_last,
    output logic [DATA_W-1:0]                               m_wdata,
    input  logic                                            m_wresp_valid,
    input  logic [1:0]                                      m_wresp,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            busy,
    output logic                                            stray_resp,
    output logic                                            timeout_flag
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        RESP
    } state_t;

    state_t               state;
    logic   [GW-1:0]      rr_ptr;
    logic   [GW-1:0]      pick_idx;
    logic   [GW-1:0]      next_ptr;
    logic   [NUM_REQ-1:0] own_mask;
    logic                 last_acc;
    logic                 timeout_hit;
    logic                 timeout_fire;
    logic                 resp_done;

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && s_wreq_valid[idx[GW-1:0]]) begin
                found    = 1'b1;
                pick_idx = idx[GW-1:0];
            end
        end
    end

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign own_mask = NUM_REQ'(1) << grant_id;
    assign last_acc = s_wdata_valid[grant_id] & m_wdata_ready & s_wdata_last[grant_id];

    // A real downstream response wins over a watchdog expiry in the same cycle.
    assign timeout_fire = timeout_hit & ~m_wresp_valid;
    assign resp_done    = m_wresp_valid | timeout_hit;

    // Datapath fields follow grant_id; handshake signals are gated by state.
    always_comb begin
        s_wreq_ready  = '0;
        s_wdata_ready = '0;
        s_wresp_valid = '0;
        s_wresp       = 2'b00;
        m_wreq_valid  = 1'b0;
        m_wdata_valid = 1'b0;
        m_wdata_last  = 1'b0;
        m_wreq_addr   = s_wreq_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        m_wreq_size   = s_wreq_size[int'(grant_id)*SIZE_W +: SIZE_W];
        m_wdata       = s_wdata[int'(grant_id)*DATA_W +: DATA_W];
        case (state)
            REQ: begin
                m_wreq_valid = s_wreq_valid[grant_id];
                s_wreq_ready = m_wreq_ready ? own_mask : '0;
            end
            DATA: begin
                m_wdata_valid = s_wdata_valid[grant_id];
                m_wdata_last  = s_wdata_last[grant_id];
                s_wdata_ready = m_wdata_ready ? own_mask : '0;
            end
            RESP: begin
                s_wresp = timeout_fire ? 2'b10 : m_wresp;
                if (resp_done) begin
                    s_wresp_valid = own_mask;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            stray_resp <= 1'b0;
        end else begin
            if (m_wresp_valid && (state != RESP)) begin
                stray_resp <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|s_wreq_valid) begin
                        grant_id <= pick_idx;
                        state    <= REQ;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    if (s_wreq_valid[grant_id] && m_wreq_ready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (last_acc) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WR_ARB_TIMEOUT_EN
    logic [31:0] resp_cnt;
    logic        timeout_reg;

    // Counter is zero in the first RESP cycle, so expiry lands on cycle TIMEOUT_CYC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_cnt    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state == DATA && last_acc) begin
                resp_cnt <= '0;
            end else if (state == RESP) begin
                resp_cnt <= resp_cnt + 32'd1;
            end
            if (timeout_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_hit  = (state == RESP) && (resp_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_flag = timeout_reg;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_s2mm_wr_arbiter.sv
// tb_s2mm_wr_arbiter
//   Scoreboard bench for s2mm_wr_arbiter with two requesters. Expected requests,
//   data beats and responses are queued in grant order when stimulus is issued
//   and popped by a negedge monitor as the DUT produces them.
module tb_s2mm_wr_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int DW = 64;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NR-1:0]    s_wreq_valid, s_wreq_ready;
    logic [NR*AW-1:0] s_wreq_addr;
    logic [NR*SW-1:0] s_wreq_size;
    logic [NR-1:0]    s_wdata_valid, s_wdata_ready, s_wdata_last;
    logic [NR*DW-1:0] s_wdata;
    logic [NR-1:0]    s_wresp_valid;
    logic [1:0]       s_wresp;
    logic             m_wreq_valid, m_wreq_ready;
    logic [AW-1:0]    m_wreq_addr;
    logic [SW-1:0]    m_wreq_size;
    logic             m_wdata_valid, m_wdata_ready, m_wdata_last;
    logic [DW-1:0]    m_wdata;
    logic             m_wresp_valid;
    logic [1:0]       m_wresp;
    logic [0:0]       grant_id;
    logic             busy, stray_resp, timeout_flag;

    always #5 clk = ~clk;

    // per-requester drive state
    logic          rv[NR], dv[NR], dl[NR];
    logic [AW-1:0] ra[NR];
    logic [SW-1:0] rs[NR];
    logic [DW-1:0] dd[NR];
    logic          auto_v = 1'b0, stray_v = 1'b0;
    logic          bp = 1'b0, resp_en = 1'b1, abort = 1'b0;
    int            resp_dly = 1;

    always_comb begin
        s_wreq_valid  = '0;
        s_wdata_valid = '0;
        s_wdata_last  = '0;
        s_wreq_addr   = '0;
        s_wreq_size   = '0;
        s_wdata       = '0;
        for (int i = 0; i < NR; i++) begin
            s_wreq_valid[i]       = rv[i];
            s_wdata_valid[i]      = dv[i];
            s_wdata_last[i]       = dl[i];
            s_wreq_addr[i*AW+:AW] = ra[i];
            s_wreq_size[i*SW+:SW] = rs[i];
            s_wdata[i*DW+:DW]     = dd[i];
        end
    end
    assign m_wresp_valid = auto_v | stray_v;

    s2mm_wr_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_W     (AW),
        .SIZE_W     (SW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_wreq_valid (s_wreq_valid),
        .s_wreq_ready (s_wreq_ready),
        .s_wreq_addr  (s_wreq_addr),
        .s_wreq_size  (s_wreq_size),
        .s_wdata_valid(s_wdata_valid),
        .s_wdata_ready(s_wdata_ready),
        .s_wdata_last (s_wdata_last),
        .s_wdata      (s_wdata),
        .s_wresp_valid(s_wresp_valid),
        .s_wresp      (s_wresp),
        .m_wreq_valid (m_wreq_valid),
        .m_wreq_ready (m_wreq_ready),
        .m_wreq_addr  (m_wreq_addr),
        .m_wreq_size  (m_wreq_size),
        .m_wdata_valid(m_wdata_valid),
        .m_wdata_ready(m_wdata_ready),
        .m_wdata_last (m_wdata_last),
        .m_wdata      (m_wdata),
        .m_wresp_valid(m_wresp_valid),
        .m_wresp      (m_wresp),
        .grant_id     (grant_id),
        .busy         (busy),
        .stray_resp   (stray_resp),
        .timeout_flag (timeout_flag)
    );

    typedef struct {int id; logic [AW-1:0] addr; logic [SW-1:0] size;} req_t;
    typedef struct {logic [DW-1:0] data; logic last;} beat_t;
    typedef struct {int id; logic [1:0] code;} resp_t;

    req_t  exp_req[$];
    beat_t exp_beat[$];
    resp_t exp_resp[$];

    int n_tests = 0;
    int n_fail  = 0;
    int beat_cnt = 0;
    int resp_seen = 0;
    int wait_cnt = 0;
    int cur_owner = 0;
    logic idle_seen = 1'b0, armed = 1'b0, in_data = 1'b0, chk_lat = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_txn(input int id, input logic [AW-1:0] a, input int nb,
                            input logic [DW-1:0] base, input logic [1:0] code);
        req_t  r;
        beat_t b;
        resp_t p;
        r.id = id; r.addr = a; r.size = SW'(nb * 8);
        exp_req.push_back(r);
        for (int i = 0; i < nb; i++) begin
            b.data = base + DW'(i);
            b.last = (i == nb - 1);
            exp_beat.push_back(b);
        end
        p.id = id; p.code = code;
        exp_resp.push_back(p);
    endtask

    // One requester transaction; exits quietly when abort is raised.
    task automatic req_txn(input int id, input logic [AW-1:0] a, input int nb, input logic [DW-1:0] base);
        int n;
        ra[id] = a;
        rs[id] = SW'(nb * 8);
        rv[id] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_wreq_ready[id] && !abort && n < 300);
        if (abort) return;
        if (n >= 300) begin check("req_wait", 0, 1); return; end
        @(posedge clk); #1;
        rv[id] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            dd[id] = base + DW'(b);
            dl[id] = (b == nb - 1);
            dv[id] = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_wdata_ready[id] && !abort && n < 300);
            if (abort) return;
            if (n >= 300) begin check("data_wait", 0, 1); return; end
            @(posedge clk); #1;
        end
        dv[id] = 1'b0;
        dl[id] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_wresp_valid[id] && !abort && n < 300);
        if (abort) return;
        if (n >= 300) begin check("resp_wait", 0, 1); return; end
        @(posedge clk); #1;
    endtask

    task automatic flush_sb();
        exp_req.delete();
        exp_beat.delete();
        exp_resp.delete();
        armed = 1'b0;
        in_data = 1'b0;
        idle_seen = 1'b0;
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_grant"}, 64'(grant_id), 0);
        check({tag, "_wreq_rdy"}, 64'(s_wreq_ready), 0);
        check({tag, "_wdata_rdy"}, 64'(s_wdata_ready), 0);
        check({tag, "_m_wreq_v"}, 64'(m_wreq_valid), 0);
        check({tag, "_m_wdata_v"}, 64'(m_wdata_valid), 0);
        check({tag, "_wresp_v"}, 64'(s_wresp_valid), 0);
        check({tag, "_stray"}, 64'(stray_resp), 0);
        check({tag, "_tflag"}, 64'(timeout_flag), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_outputs_idle("rst");
        flush_sb();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // downstream data-ready: steady 1 or toggling each cycle
    initial begin
        m_wdata_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_wdata_ready = bp ? ~m_wdata_ready : 1'b1;
        end
    end

    // downstream responder: answers resp_dly cycles into RESP
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && m_wdata_valid && m_wdata_ready && m_wdata_last && resp_en) begin
                @(posedge clk);
                repeat (resp_dly) @(posedge clk);
                #1 auto_v = 1'b1;
                @(posedge clk);
                #1 auto_v = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (!busy) idle_seen = 1'b1;
            if (in_data) begin
                check("nonowner_wdata_rdy", 64'(s_wdata_ready & ~(NR'(1) << cur_owner)), 0);
            end
            if (m_wreq_valid && m_wreq_ready) begin
                if (exp_req.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("grant_id", 64'(grant_id), 64'(r.id));
                    check("req_addr", 64'(m_wreq_addr), 64'(r.addr));
                    check("req_size", 64'(m_wreq_size), 64'(r.size));
                    check("idle_between_grants", 64'(idle_seen), 1);
                    cur_owner = r.id;
                end
                idle_seen = 1'b0;
                in_data = 1'b1;
            end
            if (m_wdata_valid && m_wdata_ready) begin
                if (exp_beat.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_beat.pop_front();
                    check("beat_data", m_wdata, b.data);
                    check("beat_last", 64'(m_wdata_last), 64'(b.last));
                end
                beat_cnt++;
                if (m_wdata_last) begin
                    armed = 1'b1;
                    wait_cnt = 0;
                end
            end else if (armed) begin
                wait_cnt++;
            end
            if (|s_wresp_valid) begin
                check("resp_after_last", 64'(armed), 1);
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    resp_t p;
                    p = exp_resp.pop_front();
                    check("resp_vec", 64'(s_wresp_valid), 64'(NR'(1) << p.id));
                    check("resp_code", 64'(s_wresp), 64'(p.code));
                end
                if (chk_lat) begin
                    check("timeout_latency", 64'(wait_cnt), 16);
                    chk_lat = 1'b0;
                end
                armed = 1'b0;
                in_data = 1'b0;
                resp_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   n, b0, r0;
        logic done;
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0; dv[i] = 1'b0; dl[i] = 1'b0;
            ra[i] = '0;   rs[i] = '0;   dd[i] = '0;
        end
        m_wreq_ready = 1'b1;
        m_wresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_idle("por");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // single requester 0, 8 beats
        push_txn(0, 32'h1000, 8, 64'd0, 2'b00);
        req_txn(0, 32'h1000, 8, 64'd0);
        @(posedge clk); #1;
        check("t1_busy", 64'(busy), 0);
        check("t1_grant", 64'(grant_id), 0);

        // fairness after reset (rr_ptr back to 0)
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_txn(0, 32'h2000 + 32'(k * 'h100), 4, 64'h100 + 64'(k * 16), 2'b00);
            push_txn(1, 32'h3000 + 32'(k * 'h100), 4, 64'h200 + 64'(k * 16), 2'b00);
        end
        fork
            for (int k = 0; k < 4; k++) req_txn(0, 32'h2000 + 32'(k * 'h100), 4, 64'h100 + 64'(k * 16));
            for (int k = 0; k < 4; k++) req_txn(1, 32'h3000 + 32'(k * 'h100), 4, 64'h200 + 64'(k * 16));
        join
        @(posedge clk); #1;
        check("t2_busy", 64'(busy), 0);

        // backpressure, 16 beats; requester 1 offers data it never owns
        bp = 1'b1;
        dv[1] = 1'b1;
        dd[1] = 64'hDEAD_BEEF;
        push_txn(0, 32'h4000, 16, 64'h400, 2'b00);
        req_txn(0, 32'h4000, 16, 64'h400);
        bp = 1'b0;
        dv[1] = 1'b0;

        // stray response during DATA, then a real one
        m_wresp = 2'b01;
        push_txn(1, 32'h5000, 4, 64'h500, 2'b01);
        done = 1'b0;
        b0 = beat_cnt;
        fork begin req_txn(1, 32'h5000, 4, 64'h500); done = 1'b1; end join_none
        n = 0;
        do begin @(negedge clk); n++; end while (beat_cnt == b0 && n < 200);
        if (n >= 200) check("t4_beat_wait", 0, 1);
        @(posedge clk); #1 stray_v = 1'b1;
        @(posedge clk); #1 stray_v = 1'b0;
        check("t4_stray_set", 64'(stray_resp), 1);
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        if (!done) check("t4_done_wait", 0, 1);
        check("t4_stray_held", 64'(stray_resp), 1);

        // reset during DATA on beat 3
        m_wresp = 2'b11;
        push_txn(0, 32'h6000, 8, 64'h600, 2'b00);
        done = 1'b0;
        b0 = beat_cnt;
        fork begin req_txn(0, 32'h6000, 8, 64'h600); done = 1'b1; end join_none
        n = 0;
        do begin @(negedge clk); n++; end while (beat_cnt < b0 + 3 && n < 200);
        if (n >= 200) check("t5_beat_wait", 0, 1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_outputs_idle("mid_rst");
        abort = 1'b1;
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (!done) check("t5_abort_wait", 0, 1);
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0; dv[i] = 1'b0; dl[i] = 1'b0;
        end
        flush_sb();
        abort = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        push_txn(1, 32'h7000, 2, 64'h700, 2'b11);
        req_txn(1, 32'h7000, 2, 64'h700);
        check("t5_tflag", 64'(timeout_flag), 0);

`ifdef WR_ARB_TIMEOUT_EN
        // watchdog: no response for owner 0, requester 1 waiting behind it
        m_wresp = 2'b00;
        resp_en = 1'b0;
        chk_lat = 1'b1;
        push_txn(0, 32'h8000, 2, 64'h800, 2'b10);
        push_txn(1, 32'h9000, 2, 64'h900, 2'b00);
        r0 = resp_seen;
        fork
            req_txn(0, 32'h8000, 2, 64'h800);
            req_txn(1, 32'h9000, 2, 64'h900);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (resp_seen == r0 && n < 200);
                if (n >= 200) check("t6_to_wait", 0, 1);
                resp_en = 1'b1;
                check("t6_tflag", 64'(timeout_flag), 1);
            end
        join
`else
        r0 = resp_seen;
        check("tflag_disabled", 64'(timeout_flag), 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("req_q_empty", 64'(exp_req.size()), 0);
        check("beat_q_empty", 64'(exp_beat.size()), 0);
        check("resp_q_empty", 64'(exp_resp.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
